vga_sync_gen: RTL and testbench

Timing generator for the 640x480 @ 60 Hz VGA display. It divides the system clock down to the pixel rate and produces the pixel_x/pixel_y scan coordinates consumed by every on-screen object in the game, such as the falling cubes. It also drives the hsync/vsync pins and the active-video flag. Sits between the board clock/reset and all pixel-coordinate consumers plus the RGB output mux.

---
 rtl/vga_sync_gen.sv | 105 ++++++++++
 tb/tb_vga_sync_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator.
// Divides the system clock down to the pixel rate, scans pixel_x/pixel_y over
// the full frame (visible area plus porches and sync), and produces registered,
// glitch-free hsync/vsync aligned with the coordinate registers.
module vga_sync_gen #(
    parameter int PIXEL_DIV = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Divider width; a divide-by-one still keeps a 1-bit counter that stays at 0.
    localparam int DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIXEL_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Sync windows compared at 11 bits so an end bound of 1024 cannot wrap.
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [9:0]       x_reg;
    logic [9:0]       x_next;
    logic [9:0]       y_reg;
    logic [9:0]       y_next;
    logic             hsync_reg;
    logic             vsync_reg;
    logic             hsync_next;
    logic             vsync_next;

    assign p_tick = (div_cnt_reg == DIV_LAST);

    // Next coordinates: x steps once per pixel tick, y steps when x wraps.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (p_tick) begin
            if (x_reg == H_LAST) begin
                x_next = 10'd0;
                if (y_reg == V_LAST) begin
                    y_next = 10'd0;
                end else begin
                    y_next = y_reg + 10'd1;
                end
            end else begin
                x_next = x_reg + 10'd1;
            end
        end
    end

    // Sync levels decoded from the next coordinates so they register on the same edge.
    always_comb begin
        hsync_next = !(({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END));
        vsync_next = !(({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END));
    end

    // State registers; reset dominates the pixel tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg <= '0;
            x_reg       <= 10'd0;
            y_reg       <= 10'd0;
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
        end else begin
            div_cnt_reg <= p_tick ? '0 : div_cnt_reg + DIV_W'(1);
            x_reg       <= x_next;
            y_reg       <= y_next;
            hsync_reg   <= hsync_next;
            vsync_reg   <= vsync_next;
        end
    end

    assign pixel_x   = x_reg;
    assign pixel_y   = y_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign video_on  = ({1'b0, x_reg} < H_VIS_W) && ({1'b0, y_reg} < V_VIS_W);
    assign frame_end = p_tick && (x_reg == H_LAST) && (y_reg == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: three instances (default timing, tiny timing with
// divide-by-one, and a mid-size timing with divide-by-two) checked every cycle
// against a model that derives the whole scan state from the cycle count.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fe;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    logic [9:0] ax, ay, bx, by, cx, cy;
    logic ah, av, avo, ap, af;
    logic bh, bv, bvo, bp, bf;
    logic ch, cv, cvo, cp, cf;

    int errors = 0;
    int checks = 0;

    // Cycles since the last reset edge for each instance.
    int ta = 0;
    int tb = 0;
    int tc = 0;

    vga_sync_gen u_a (
        .clk(clk), .reset(rst_a), .pixel_x(ax), .pixel_y(ay), .hsync(ah),
        .vsync(av), .video_on(avo), .p_tick(ap), .frame_end(af)
    );

    vga_sync_gen #(
        .PIXEL_DIV(1), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (
        .clk(clk), .reset(rst_b), .pixel_x(bx), .pixel_y(by), .hsync(bh),
        .vsync(bv), .video_on(bvo), .p_tick(bp), .frame_end(bf)
    );

    vga_sync_gen #(
        .PIXEL_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_c (
        .clk(clk), .reset(rst_c), .pixel_x(cx), .pixel_y(cy), .hsync(ch),
        .vsync(cv), .video_on(cvo), .p_tick(cp), .frame_end(cf)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = '{x: ax, y: ay, hs: ah, vs: av, von: avo, pt: ap, fe: af};
    assign obs_b = '{x: bx, y: by, hs: bh, vs: bv, von: bvo, pt: bp, fe: bf};
    assign obs_c = '{x: cx, y: cy, hs: ch, vs: cv, von: cvo, pt: cp, fe: cf};

    always @(posedge clk) begin
        ta <= rst_a ? 0 : ta + 1;
        tb <= rst_b ? 0 : tb + 1;
        tc <= rst_c ? 0 : tc + 1;
    end

    // Scan state after t clocks of free running: pixel index t/div, raster order.
    function automatic obs_t model(int t, int div, int hv, int hfp, int hs, int hb,
                                   int vv, int vfp, int vs, int vb);
        obs_t o;
        int ht, vt, idx, x, y;
        ht  = hv + hfp + hs + hb;
        vt  = vv + vfp + vs + vb;
        idx = t / div;
        x   = idx % ht;
        y   = (idx / ht) % vt;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.pt  = ((t % div) == div - 1);
        o.hs  = !((x >= hv + hfp) && (x < hv + hfp + hs));
        o.vs  = !((y >= vv + vfp) && (y < vv + vfp + vs));
        o.von = (x < hv) && (y < vv);
        o.fe  = o.pt && (x == ht - 1) && (y == vt - 1);
        return o;
    endfunction

    function automatic obs_t model_a(int t);
        return model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic obs_t model_b(int t);
        return model(t, 1, 4, 1, 2, 1, 3, 1, 1, 1);
    endfunction
    function automatic obs_t model_c(int t);
        return model(t, 2, 16, 2, 4, 2, 12, 2, 2, 3);
    endfunction

    // Reset values, first tick latency after release, and a random mid-frame reset.
    task automatic test_reset();
        obs_t e;
        int edges;
        int run;
        rst_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs_a !== '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, pt: 1'b0, fe: 1'b0}) begin
                errors++;
                $display("FAIL reset_values: got %h required x=0 y=0 hs=1 vs=1 von=1 pt=0 fe=0", obs_a);
            end
        end
        rst_a = 1'b0;
        edges = 0;
        while (ap !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != 3) begin
            errors++;
            $display("FAIL first_ptick: got after %0d edges required 3", edges);
        end
        @(negedge clk);
        checks++;
        if (ax !== 10'd1) begin
            errors++;
            $display("FAIL first_pixel_step: got x=%0d required 1", ax);
        end
        run = 2000 + int'($urandom_range(4000));
        repeat (run) begin
            @(negedge clk);
            e = model_a(ta);
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL run_a t=%0d: got %h required %h", ta, obs_a, e);
            end
        end
        $display("test_reset: mid-frame reset at x=%0d y=%0d after %0d clks", ax, ay, run);
        rst_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (obs_a !== '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, pt: 1'b0, fe: 1'b0}) begin
                errors++;
                $display("FAIL midframe_reset: got %h required x=0 y=0 hs=1 vs=1 von=1 pt=0 fe=0", obs_a);
            end
        end
        rst_a = 1'b0;
    endtask

    // Tick rate is one in four clocks and x steps by exactly one per tick.
    task automatic test_pixel_rate();
        int ticks;
        logic [9:0] px;
        logic ppt;
        obs_t e;
        ticks = 0;
        @(negedge clk);
        px  = ax;
        ppt = ap;
        repeat (400) begin
            @(negedge clk);
            e = model_a(ta);
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL rate_model t=%0d: got %h required %h", ta, obs_a, e);
            end
            checks++;
            if (ax !== (ppt ? ((px == 10'd799) ? 10'd0 : px + 10'd1) : px)) begin
                errors++;
                $display("FAIL x_step: got x=%0d from x=%0d tick=%b", ax, px, ppt);
            end
            if (ap === 1'b1) ticks++;
            px  = ax;
            ppt = ap;
        end
        checks++;
        if (ticks != 100) begin
            errors++;
            $display("FAIL tick_count: got %0d required 100", ticks);
        end
        $display("test_pixel_rate: %0d ticks in 400 clks", ticks);
    endtask

    // Over two lines: hsync edges at x=656/752, video_on falls at x=640, line wrap bumps y.
    task automatic test_hsync_window();
        logic ph, pvo;
        logic [9:0] px, py;
        obs_t e;
        int falls, rises, vfalls, wraps;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        falls = 0; rises = 0; vfalls = 0; wraps = 0;
        @(negedge clk);
        ph = ah; pvo = avo; px = ax; py = ay;
        repeat (6500) begin
            @(negedge clk);
            e = model_a(ta);
            checks++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL line_model t=%0d: got %h required %h", ta, obs_a, e);
            end
            if (ph && !ah) begin
                falls++; checks++;
                if (ax !== 10'd656) begin
                    errors++;
                    $display("FAIL hsync_fall: got x=%0d required 656", ax);
                end
            end
            if (!ph && ah) begin
                rises++; checks++;
                if (ax !== 10'd752) begin
                    errors++;
                    $display("FAIL hsync_rise: got x=%0d required 752", ax);
                end
            end
            if (pvo && !avo) begin
                vfalls++; checks++;
                if (ax !== 10'd640) begin
                    errors++;
                    $display("FAIL video_fall: got x=%0d required 640", ax);
                end
            end
            if (px == 10'd799 && ax == 10'd0) begin
                wraps++; checks++;
                if (ay !== py + 10'd1) begin
                    errors++;
                    $display("FAIL line_wrap: got y=%0d required %0d", ay, py + 10'd1);
                end
            end
            ph = ah; pvo = avo; px = ax; py = ay;
        end
        checks++;
        if (falls != 2 || rises != 2 || vfalls != 2 || wraps != 2) begin
            errors++;
            $display("FAIL line_events: got falls=%0d rises=%0d vfalls=%0d wraps=%0d required 2 each",
                     falls, rises, vfalls, wraps);
        end
        $display("test_hsync_window: falls=%0d rises=%0d wraps=%0d", falls, rises, wraps);
    endtask

    // Tiny timing, divide-by-one: 8-clk lines, 48-clk frames, sync at x=5..6 and y=4.
    task automatic test_small_frame();
        obs_t e;
        int fe_cnt, last_fe, run;
        rst_b = 1'b0;
        fe_cnt = 0;
        last_fe = -1;
        run = 144 + int'($urandom_range(40));
        repeat (run) begin
            @(negedge clk);
            e = model_b(tb);
            checks++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL small_model t=%0d: got %h required %h", tb, obs_b, e);
            end
            checks++;
            if (bh !== !(bx == 10'd5 || bx == 10'd6) || bv !== (by != 10'd4)) begin
                errors++;
                $display("FAIL small_sync: got hs=%b vs=%b at x=%0d y=%0d", bh, bv, bx, by);
            end
            if (bf === 1'b1) begin
                if (last_fe >= 0) begin
                    checks++;
                    if (tb - last_fe != 48) begin
                        errors++;
                        $display("FAIL small_frame_period: got %0d required 48", tb - last_fe);
                    end
                end
                last_fe = tb;
                fe_cnt++;
            end
        end
        checks++;
        if (fe_cnt != run / 48) begin
            errors++;
            $display("FAIL small_frame_count: got %0d required %0d", fe_cnt, run / 48);
        end
        $display("test_small_frame: %0d frame_end pulses in %0d clks", fe_cnt, run);
    endtask

    // Mid-size timing over two frames: frame wrap to (0,0), vsync width and count.
    task automatic test_frame_wrap();
        obs_t e;
        int fe_cnt, pulses, low_len;
        logic pfe;
        rst_c = 1'b0;
        fe_cnt = 0; pulses = 0; low_len = 0; pfe = 1'b0;
        repeat (2 * 912) begin
            @(negedge clk);
            e = model_c(tc);
            checks++;
            if (obs_c !== e) begin
                errors++;
                $display("FAIL frame_model t=%0d: got %h required %h", tc, obs_c, e);
            end
            if (pfe) begin
                checks++;
                if (cx !== 10'd0 || cy !== 10'd0 || cvo !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_wrap: got x=%0d y=%0d von=%b required 0 0 1", cx, cy, cvo);
                end
            end
            if (cf === 1'b1) fe_cnt++;
            if (cv === 1'b0) begin
                if (low_len == 0) pulses++;
                low_len++;
            end else if (low_len != 0) begin
                checks++;
                if (low_len != 96) begin
                    errors++;
                    $display("FAIL vsync_width: got %0d clks required 96", low_len);
                end
                low_len = 0;
            end
            pfe = cf;
        end
        checks++;
        if (fe_cnt != 2 || pulses != 2) begin
            errors++;
            $display("FAIL frame_counts: got fe=%0d vs_pulses=%0d required 2 2", fe_cnt, pulses);
        end
        $display("test_frame_wrap: fe=%0d vsync pulses=%0d", fe_cnt, pulses);
    endtask

    // Random reset pulses at random points, model compared every cycle.
    task automatic test_back_to_back();
        obs_t e;
        int gap, hold;
        for (int i = 0; i < 6; i++) begin
            gap  = 1 + int'($urandom_range(900));
            hold = 1 + int'($urandom_range(4));
            repeat (gap) begin
                @(negedge clk);
                e = model_c(tc);
                checks++;
                if (obs_c !== e) begin
                    errors++;
                    $display("FAIL b2b_run t=%0d: got %h required %h", tc, obs_c, e);
                end
            end
            rst_c = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                e = model_c(tc);
                checks++;
                if (obs_c !== e || cp !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_reset: got %h required %h", obs_c, e);
                end
            end
            rst_c = 1'b0;
            $display("test_back_to_back: pulse %0d gap=%0d hold=%0d", i, gap, hold);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_pixel_rate();
        test_hsync_window();
        test_small_frame();
        rst_c = 1'b1;
        @(negedge clk);
        test_frame_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
